mips_multicycle_ctrl: RTL
=========================

Name: mips_multicycle_ctrl

Overview:
Moore-FSM control unit that sequences the shared 32-bit ALU, register file, memory and PC of the multicycle MIPS datapath. One instruction takes 3-5 clocks: fetch, decode, then the per-class execute/memory/writeback states. It also contains the ALU function decoder that drives the ALU's 3-bit f input, and forms the PC enable from the ALU zero flag.

Parameters:
none (opcode/funct encodings fixed to MIPS-I).

Ports:
clk        in   1  rising-edge clock
rst_n      in   1  asynchronous active-low reset
op         in   6  instr[31:26] from IR
funct      in   6  instr[5:0] from IR
zero       in   1  ALU zero flag, current cycle
pcen       out  1  PC register enable
irwrite    out  1  IR load enable
memwrite   out  1  memory write strobe
regwrite   out  1  register file write enable
iord       out  1  mem addr mux: 0=PC, 1=ALUOut
memtoreg   out  1  RF wdata: 0=ALUOut, 1=MDR
regdst     out  1  RF waddr: 0=rt, 1=rd
alusrca    out  1  ALU a: 0=PC, 1=A reg
alusrcb    out  2  ALU b: 00=B, 01=4, 10=SignImm, 11=SignImm<<2
pcsrc      out  2  PC next: 00=ALU y, 01=ALUOut, 10=jump target
alucontrol out  3  ALU f
state      out  4  current state (debug)

Behaviour:
- State register only sequential element; all outputs combinational decode of state, op, funct, zero.
- rst_n low: state=FETCH(0) immediately; pcen, irwrite, memwrite, regwrite forced 0 while rst_n low; other outputs take FETCH values. First FETCH action on first rising edge after release.
- Encodings/transitions:
  FETCH(0) -> DECODE
  DECODE(1): op 100011/101011 -> MEMADR; 000000 -> EXECUTE; 000100 -> BRANCH; 001000 -> ADDIEX; 000010 -> JUMP; any other -> FETCH (NOP, no strobes)
  MEMADR(2): op 100011 -> MEMRD, 101011 -> MEMWR
  MEMRD(3) -> MEMWB(4) -> FETCH
  MEMWR(5) -> FETCH
  EXECUTE(6) -> ALUWB(7) -> FETCH
  BRANCH(8) -> FETCH
  ADDIEX(9) -> ADDIWB(10) -> FETCH
  JUMP(11) -> FETCH
  Codes 12-15 -> FETCH next cycle, all strobes 0.
- Per-state asserted outputs (unlisted = 0):
  FETCH: iord=0, alusrca=0, alusrcb=01, aluop=00, pcsrc=00, irwrite=1, pcwrite=1
  DECODE: alusrca=0, alusrcb=11, aluop=00
  MEMADR: alusrca=1, alusrcb=10, aluop=00
  MEMRD: iord=1
  MEMWB: regdst=0, memtoreg=1, regwrite=1
  MEMWR: iord=1, memwrite=1
  EXECUTE: alusrca=1, alusrcb=00, aluop=10
  ALUWB: regdst=1, memtoreg=0, regwrite=1
  BRANCH: alusrca=1, alusrcb=00, aluop=01, pcsrc=01, branch=1
  ADDIEX: alusrca=1, alusrcb=10, aluop=00
  ADDIWB: regdst=0, memtoreg=0, regwrite=1
  JUMP: pcsrc=10, pcwrite=1
- pcen = pcwrite | (branch & zero). zero sampled same cycle as BRANCH (combinational).
- ALU decoder: aluop 00 -> 010 (add); 01 -> 110 (sub); 10 by funct: 100000->010, 100010->110, 100100->000, 100101->001, 101010->111 (slt); any other funct -> 011 (ALU yields 0). aluop 11 never produced; decode as 010.
- aluop internal, not a port.

Optional Feature:
MIPS_CTRL_BNE_EN: defined -> DECODE op 000101 -> BRANCH_NE(12): outputs as BRANCH but branch=0, bne=1; pcen |= bne & ~zero; then FETCH. Undefined -> op 000101 is NOP (DECODE -> FETCH), state 12 unreachable, treated as illegal.

Test Plan:
- Reset held 3 clocks, release: state=0, pcen/irwrite/regwrite/memwrite=0 during reset; first post-reset cycle irwrite=1, pcen=1, alusrcb=01, alucontrol=010.
- op=000000 funct=101010: states 0,1,6,7,0; EXECUTE alucontrol=111, ALUWB regdst=1 regwrite=1; funct=100111 -> alucontrol=011.
- op=100011: states 0,1,2,3,4,0 with iord=1 in 3, memtoreg=1 regwrite=1 in 4; op=101011: 0,1,2,5,0 with memwrite=1 only in 5.
- op=000100, zero=1 in BRANCH -> pcen=1, pcsrc=01, alucontrol=110; zero=0 -> pcen=0; op=000010 -> JUMP pcen=1 pcsrc=10.
- op=111111 -> 0,1,0 with no strobes; rst_n low mid-MEMWR -> memwrite drops immediately, state=0.
- MIPS_CTRL_BNE_EN: op=000101 zero=0 -> state 12, pcen=1; zero=1 -> pcen=0; macro off -> 0,1,0, no pcen in DECODE.

Source files
------------

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control unit: Moore FSM that sequences the shared ALU,
// register file, memory and PC, plus the ALU function decoder and PC enable.
//
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   op, funct          instr[31:26] / instr[5:0] from the IR
//   zero               ALU zero flag (current cycle)
//   pcen               PC enable = pcwrite | (branch & zero)
//   irwrite, memwrite, regwrite   strobes, forced low while in reset
//   iord, memtoreg, regdst, alusrca, alusrcb, pcsrc   datapath mux selects
//   alucontrol         ALU function select
//   state              current state (debug)
//
// Optional feature: define MIPS_CTRL_BNE_EN to add bne via state BRANCH_NE(12).
// Without it, bne decodes as a NOP and state 12 is an illegal code.
//
// Outputs are a combinational decode of the state register by design: the
// datapath consumes them in the same cycle the state is entered.
module mips_multicycle_ctrl (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [5:0] op,
   input  logic [5:0] funct,
   input  logic       zero,
   output logic       pcen,
   output logic       irwrite,
   output logic       memwrite,
   output logic       regwrite,
   output logic       iord,
   output logic       memtoreg,
   output logic       regdst,
   output logic       alusrca,
   output logic [1:0] alusrcb,
   output logic [1:0] pcsrc,
   output logic [2:0] alucontrol,
   output logic [3:0] state
);

   localparam int unsigned SW = 4;

   localparam logic [SW-1:0] S_FETCH     = SW'(0);
   localparam logic [SW-1:0] S_DECODE    = SW'(1);
   localparam logic [SW-1:0] S_MEMADR    = SW'(2);
   localparam logic [SW-1:0] S_MEMRD     = SW'(3);
   localparam logic [SW-1:0] S_MEMWB     = SW'(4);
   localparam logic [SW-1:0] S_MEMWR     = SW'(5);
   localparam logic [SW-1:0] S_EXECUTE   = SW'(6);
   localparam logic [SW-1:0] S_ALUWB     = SW'(7);
   localparam logic [SW-1:0] S_BRANCH    = SW'(8);
   localparam logic [SW-1:0] S_ADDIEX    = SW'(9);
   localparam logic [SW-1:0] S_ADDIWB    = SW'(10);
   localparam logic [SW-1:0] S_JUMP      = SW'(11);
`ifdef MIPS_CTRL_BNE_EN
   localparam logic [SW-1:0] S_BRANCH_NE = SW'(12);
`endif

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;
`ifdef MIPS_CTRL_BNE_EN
   localparam logic [5:0] OP_BNE   = 6'b000101;
`endif

   logic [SW-1:0] state_nx;
   logic [1:0]    aluop;
   logic          pcwrite;
   logic          branch;
   logic          bne;
   logic          irwrite_s;
   logic          memwrite_s;
   logic          regwrite_s;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_FETCH;
      else        state <= state_nx;
   end

   // Next-state logic; unused codes fall back to FETCH
   always_comb begin
      state_nx = S_FETCH;
      case (state)
         S_FETCH:  state_nx = S_DECODE;
         S_DECODE: begin
            case (op)
               OP_LW, OP_SW: state_nx = S_MEMADR;
               OP_RTYPE:     state_nx = S_EXECUTE;
               OP_BEQ:       state_nx = S_BRANCH;
               OP_ADDI:      state_nx = S_ADDIEX;
               OP_J:         state_nx = S_JUMP;
`ifdef MIPS_CTRL_BNE_EN
               OP_BNE:       state_nx = S_BRANCH_NE;
`endif
               default:      state_nx = S_FETCH;
            endcase
         end
         S_MEMADR:  state_nx = (op == OP_SW) ? S_MEMWR : S_MEMRD;
         S_MEMRD:   state_nx = S_MEMWB;
         S_EXECUTE: state_nx = S_ALUWB;
         S_ADDIEX:  state_nx = S_ADDIWB;
         default:   state_nx = S_FETCH;
      endcase
   end

   // Output decode
   always_comb begin
      pcwrite    = 1'b0;
      branch     = 1'b0;
      bne        = 1'b0;
      irwrite_s  = 1'b0;
      memwrite_s = 1'b0;
      regwrite_s = 1'b0;
      iord       = 1'b0;
      memtoreg   = 1'b0;
      regdst     = 1'b0;
      alusrca    = 1'b0;
      alusrcb    = 2'b00;
      pcsrc      = 2'b00;
      aluop      = 2'b00;
      case (state)
         S_FETCH: begin
            alusrcb   = 2'b01;
            irwrite_s = 1'b1;
            pcwrite   = 1'b1;
         end
         S_DECODE:  alusrcb = 2'b11;
         S_MEMADR: begin
            alusrca = 1'b1;
            alusrcb = 2'b10;
         end
         S_MEMRD:   iord = 1'b1;
         S_MEMWB: begin
            memtoreg   = 1'b1;
            regwrite_s = 1'b1;
         end
         S_MEMWR: begin
            iord       = 1'b1;
            memwrite_s = 1'b1;
         end
         S_EXECUTE: begin
            alusrca = 1'b1;
            aluop   = 2'b10;
         end
         S_ALUWB: begin
            regdst     = 1'b1;
            regwrite_s = 1'b1;
         end
         S_BRANCH: begin
            alusrca = 1'b1;
            aluop   = 2'b01;
            pcsrc   = 2'b01;
            branch  = 1'b1;
         end
         S_ADDIEX: begin
            alusrca = 1'b1;
            alusrcb = 2'b10;
         end
         S_ADDIWB:  regwrite_s = 1'b1;
         S_JUMP: begin
            pcsrc   = 2'b10;
            pcwrite = 1'b1;
         end
`ifdef MIPS_CTRL_BNE_EN
         S_BRANCH_NE: begin
            alusrca = 1'b1;
            aluop   = 2'b01;
            pcsrc   = 2'b01;
            bne     = 1'b1;
         end
`endif
         default: ;
      endcase
   end

   // ALU function decoder; unknown R-type functs select 011, which yields 0
   always_comb begin
      alucontrol = 3'b010;
      case (aluop)
         2'b01: alucontrol = 3'b110;
         2'b10: begin
            case (funct)
               6'b100000: alucontrol = 3'b010;
               6'b100010: alucontrol = 3'b110;
               6'b100100: alucontrol = 3'b000;
               6'b100101: alucontrol = 3'b001;
               6'b101010: alucontrol = 3'b111;
               default:   alucontrol = 3'b011;
            endcase
         end
         default: alucontrol = 3'b010;
      endcase
   end

   // Architectural strobes are held off for the whole reset assertion
   always_comb begin
      pcen     = rst_n & (pcwrite | (branch & zero) | (bne & ~zero));
      irwrite  = rst_n & irwrite_s;
      memwrite = rst_n & memwrite_s;
      regwrite = rst_n & regwrite_s;
   end

endmodule
